mt_frame_unpacker: RTL and testbench
====================================

// Module: mt_frame_unpacker
// PURPOSE
//  Read-side tape formatter datapath. Accepts 8-bit tape frames from the
//  transport and packs them into 36-bit KS10 words, using the format and
//  parity-sense fields of the tape control register.
//  Maintains the frame counter and drives frame-count status (FCS) back into
//  the tape control register. Sits between the transport frame stream and the
//  Massbus data buffer.
// PARAMETERS
//  FCW        16   frame counter width (bits)
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous reset, active high
//  mtINIT     in   1    controller initialize; same effect as rst
//  mtTC       in   16   tape control register: FMT=[7:4], EVPAR=[3]
//  mtGO       in   1    1-cycle pulse: start a read-forward operation
//  mtFCLD     in   1    load frame counter from mtDATAI[FCW-1:0]
//  mtDATAI    in   36   host write data
//  frmVALID   in   1    transport frame valid
//  frmREADY   out  1    unpacker accepts frame (valid & ready = transfer)
//  frmDATA    in   8    frame data
//  frmPAR     in   1    frame parity bit
//  frmEOR     in   1    end-of-record marker; qualified by frmVALID, carries no data
//  wordVALID  out  1    assembled word available
//  wordREADY  in   1    downstream accepts word
//  wordDATA   out  36   assembled word
//  mtFC       out  FCW  frame counter
//  mtFCS      out  1    frame-count status: (mtFC != 0)
//  mtFMTERR   out  1    sticky: unsupported format at GO
//  mtPERR     out  1    sticky: frame parity error
//  mtDONE     out  1    1-cycle pulse: operation finished
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset/mtINIT: state=IDLE, all outputs 0, mtFC=0, partial word discarded.
//   Applies at any point, including mid-record.
//  States:
//   IDLE   - frmREADY=0. On mtGO: clear FMTERR/PERR and the frame index.
//            FMT=0 (core dump) or FMT=3 (compatible) -> ACTIVE.
//            Any other FMT -> set FMTERR, go to DONE.
//   ACTIVE - frmREADY=1. Each data transfer stores a frame at index k, then
//            increments k and mtFC (mod 2^FCW).
//   HOLD   - wordVALID=1, frmREADY=0. On wordREADY -> ACTIVE, or -> DONE if
//            the word was flushed by EOR.
//   DONE   - mtDONE=1 for exactly one cycle, then -> IDLE.
//  Packing, core dump (5 frames/word):
//   f0->[35:28], f1->[27:20], f2->[19:12], f3->[11:4], f4[3:0]->[3:0].
//   f4[7:4] is discarded.
//  Packing, compatible (4 frames/word): f0..f3->[35:4]; [3:0]=0.
//  Word completion: wordVALID asserts the cycle after the final frame is
//   accepted. Latency is 1 clock.
//  EOR in ACTIVE:
//   k>0  -> unfilled bits are 0, word goes to HOLD, then DONE.
//   k==0 -> straight to DONE, no word.
//   EOR does not count as a frame.
//  mtFCLD: loads mtFC in any state and wins over a same-cycle increment.
//   mtFC wraps 16'hFFFF->0, which drops FCS.
//  mtGO outside IDLE is ignored.
//  wordDATA is held stable while wordVALID=1.
// CONFIGURATION
//  MT_PARCHK_EN defined:
//   Frame parity is checked. Expected parity is odd, or even when EVPAR=1.
//   A mismatch sets mtPERR (sticky until the next GO).
//   The frame is still packed, and the transfer continues.
//  MT_PARCHK_EN undefined:
//   frmPAR is ignored and mtPERR is constant 0.
// TESTING
//  1. FMT=0, GO, frames 12,34,56,78,9A -> wordDATA=36'h123456789A? no:
//     [35:4]=32'h12345678, [3:0]=4'hA -> 36'h12345678A. FC=5, FCS=1.
//  2. FMT=3, frames DE,AD,BE,EF, then EOR -> 36'hDEADBEEF0, then mtDONE
//     1 cycle later than word accept.
//  3. FMT=3, 2 frames 11,22 then EOR -> 36'h112200000 flushed.
//     EOR with k=0 -> mtDONE, no wordVALID.
//  4. FMT=5, GO -> mtFMTERR=1, mtDONE pulse, frmREADY never 1.
//  5. FCLD 16'hFFFE, two frames -> FC=0, FCS=0.
//     wordREADY low for 10 cycles -> frmREADY=0 and wordDATA stable.
//  6. MT_PARCHK_EN, EVPAR=0, frame 8'h01 with PAR=1 -> mtPERR=1.
//     Assert rst mid-word -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mt_frame_unpacker.sv
// Read-side tape formatter: packs 8-bit transport frames into 36-bit KS10 words.
// Optional frame parity checking is enabled by defining MT_PARCHK_EN.
module mt_frame_unpacker #(
    parameter int FCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mtINIT,
    input  logic [15:0]    mtTC,
    input  logic           mtGO,
    input  logic           mtFCLD,
    input  logic [35:0]    mtDATAI,
    input  logic           frmVALID,
    output logic           frmREADY,
    input  logic [7:0]     frmDATA,
    input  logic           frmPAR,
    input  logic           frmEOR,
    output logic           wordVALID,
    input  logic           wordREADY,
    output logic [35:0]    wordDATA,
    output logic [FCW-1:0] mtFC,
    output logic           mtFCS,
    output logic           mtFMTERR,
    output logic           mtPERR,
    output logic           mtDONE
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD, S_DONE} state_t;

    state_t         state_q;
    logic           coredump_q, evpar_q, flush_q;
    logic           rdy_q, wvld_q, done_q, fmterr_q, perr_q;
    logic [2:0]     k_q;
    logic [35:0]    word_q;
    logic [FCW-1:0] fc_q, fc_d;
    logic           data_xfer, eor_xfer, last_frame, par_bad, fmt_ok;

    function automatic logic [35:0] pack_frame(input logic [35:0] w, input logic [2:0] k,
                                               input logic [7:0] f);
        logic [35:0] r;
        r = w;
        case (k)
            3'd0:    r[35:28] = f;
            3'd1:    r[27:20] = f;
            3'd2:    r[19:12] = f;
            3'd3:    r[11:4]  = f;
            default: r[3:0]   = f[3:0];
        endcase
        return r;
    endfunction

    assign data_xfer  = frmVALID && rdy_q && !frmEOR;
    assign eor_xfer   = frmVALID && rdy_q && frmEOR;
    assign last_frame = coredump_q ? (k_q == 3'd4) : (k_q == 3'd3);
    assign fmt_ok     = (mtTC[7:4] == 4'd0) || (mtTC[7:4] == 4'd3);

`ifdef MT_PARCHK_EN
    // Odd parity over data+parity bit expected; even when EVPAR is set.
    assign par_bad = data_xfer && ((^{frmDATA, frmPAR}) == evpar_q);
    logic unused_in;
    assign unused_in = ^{mtTC[15:8], mtTC[2:0], mtDATAI[35:FCW]};
`else
    assign par_bad = 1'b0;
    logic unused_in;
    assign unused_in = ^{mtTC[15:8], mtTC[2:0], mtDATAI[35:FCW], frmPAR, evpar_q};
`endif

    assign frmREADY  = rdy_q;
    assign wordVALID = wvld_q;
    assign wordDATA  = word_q;
    assign mtFC      = fc_q;
    assign mtFCS     = (fc_q != '0);
    assign mtFMTERR  = fmterr_q;
    assign mtPERR    = perr_q;
    assign mtDONE    = done_q;

    // A host load of the counter takes priority over a frame increment.
    always_comb begin
        fc_d = fc_q;
        if (mtFCLD)
            fc_d = mtDATAI[FCW-1:0];
        else if (data_xfer)
            fc_d = fc_q + FCW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || mtINIT) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b0;
            wvld_q     <= 1'b0;
            done_q     <= 1'b0;
            fmterr_q   <= 1'b0;
            perr_q     <= 1'b0;
            flush_q    <= 1'b0;
            coredump_q <= 1'b0;
            evpar_q    <= 1'b0;
            k_q        <= 3'd0;
            word_q     <= '0;
            fc_q       <= '0;
        end else begin
            fc_q   <= fc_d;
            done_q <= 1'b0;
            if (par_bad)
                perr_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (mtGO) begin
                        fmterr_q   <= 1'b0;
                        perr_q     <= 1'b0;
                        flush_q    <= 1'b0;
                        k_q        <= 3'd0;
                        word_q     <= '0;
                        coredump_q <= (mtTC[7:4] == 4'd0);
                        evpar_q    <= mtTC[3];
                        if (fmt_ok) begin
                            state_q <= S_ACTIVE;
                            rdy_q   <= 1'b1;
                        end else begin
                            fmterr_q <= 1'b1;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (data_xfer) begin
                        word_q <= pack_frame(word_q, k_q, frmDATA);
                        k_q    <= k_q + 3'd1;
                        if (last_frame) begin
                            state_q <= S_HOLD;
                            rdy_q   <= 1'b0;
                            wvld_q  <= 1'b1;
                            flush_q <= 1'b0;
                        end
                    end else if (eor_xfer) begin
                        rdy_q <= 1'b0;
                        if (k_q != 3'd0) begin
                            state_q <= S_HOLD;
                            wvld_q  <= 1'b1;
                            flush_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // Word register stays frozen until the consumer takes it.
                    if (wordREADY) begin
                        wvld_q <= 1'b0;
                        word_q <= '0;
                        k_q    <= 3'd0;
                        if (flush_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ACTIVE;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mt_frame_unpacker.sv
// Bench for mt_frame_unpacker: directed vector table, corner sequences, and a
// randomized run scored against a word-level reference model.
module tb_mt_frame_unpacker;

    logic        clk = 1'b0;
    logic        rst, mtINIT, mtGO, mtFCLD, frmVALID, frmPAR, frmEOR, wordREADY;
    logic [15:0] mtTC;
    logic [35:0] mtDATAI;
    logic [7:0]  frmDATA;
    logic        frmREADY, wordVALID, mtFCS, mtFMTERR, mtPERR, mtDONE;
    logic [35:0] wordDATA;
    logic [15:0] mtFC;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mt_frame_unpacker #(.FCW(16)) dut (
        .clk(clk), .rst(rst), .mtINIT(mtINIT), .mtTC(mtTC), .mtGO(mtGO),
        .mtFCLD(mtFCLD), .mtDATAI(mtDATAI), .frmVALID(frmVALID), .frmREADY(frmREADY),
        .frmDATA(frmDATA), .frmPAR(frmPAR), .frmEOR(frmEOR), .wordVALID(wordVALID),
        .wordREADY(wordREADY), .wordDATA(wordDATA), .mtFC(mtFC), .mtFCS(mtFCS),
        .mtFMTERR(mtFMTERR), .mtPERR(mtPERR), .mtDONE(mtDONE)
    );

    typedef struct {
        logic [3:0]  fmt;
        int          n;
        bit          eor;
        logic [39:0] fr;
        logic [35:0] word;
        bit          fmterr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {6'd0, frmREADY, wordVALID, wordDATA, mtFC, mtFCS, mtFMTERR, mtPERR, mtDONE};
    endfunction

    function automatic logic good_par(input logic [7:0] d, input logic ev);
        return (($countones(d) % 2) == 0) ? !ev : ev;
    endfunction

    function automatic logic [35:0] model_word(input logic [7:0] q[$], input bit core);
        longint w = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (core && i == 4) w += longint'(q[i] % 16);
            else                w += longint'(q[i]) << (28 - 8 * i);
        end
        return w[35:0];
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_state", outs(), 64'd0);
        rst = 1'b0;
    endtask

    task automatic go(input logic [3:0] fmt, input logic ev);
        mtTC = {8'h00, fmt, ev, 3'b000};
        mtGO = 1'b1;
        @(negedge clk);
        mtGO = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic e);
        frmDATA = d; frmPAR = p; frmEOR = e; frmVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (frmREADY) begin
                @(posedge clk);
                @(negedge clk);
                frmVALID = 1'b0; frmEOR = 1'b0;
                return;
            end
            @(negedge clk);
        end
        frmVALID = 1'b0; frmEOR = 1'b0;
        checks++; failures++;
        $display("FAIL frame_handshake timeout frmREADY=0 required=1");
    endtask

    task automatic expect_word(input string name, input logic [35:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (wordVALID) begin
                chk(name, 64'(wordDATA), 64'(exp));
                chk({name, "_rdy_low"}, 64'(frmREADY), 64'd0);
                wordREADY = 1'b1;
                @(negedge clk);
                wordREADY = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++; failures++;
        $display("FAIL %s timeout wordVALID=0 required=1", name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fc_m;
        logic [7:0]  cur[$];
        logic [7:0]  d;
        logic        p, ev, perr_m, perr_exp;
        bit          core;
        int          n, fpw;

        rst = 1'b1; mtINIT = 1'b0; mtGO = 1'b0; mtFCLD = 1'b0; mtTC = '0; mtDATAI = '0;
        frmVALID = 1'b0; frmDATA = '0; frmPAR = 1'b0; frmEOR = 1'b0; wordREADY = 1'b0;

        vecs[0]  = '{4'd0, 5, 1'b0, 40'h123456789A, 36'h12345678A, 1'b0};
        vecs[1]  = '{4'd3, 4, 1'b1, 40'hDEADBEEF00, 36'hDEADBEEF0, 1'b0};
        vecs[2]  = '{4'd3, 2, 1'b1, 40'h1122000000, 36'h112200000, 1'b0};
        vecs[3]  = '{4'd0, 3, 1'b1, 40'hABCDEF0000, 36'hABCDEF000, 1'b0};
        vecs[4]  = '{4'd0, 0, 1'b1, 40'h0,          36'h0,         1'b0};
        vecs[5]  = '{4'd5, 0, 1'b0, 40'h0,          36'h0,         1'b1};
        vecs[6]  = '{4'd0, 5, 1'b0, 40'hFFFFFFFFFF, 36'hFFFFFFFFF, 1'b0};
        vecs[7]  = '{4'd3, 1, 1'b1, 40'h5A00000000, 36'h5A0000000, 1'b0};
        vecs[8]  = '{4'd0, 4, 1'b1, 40'h0102030400, 36'h010203040, 1'b0};
        vecs[9]  = '{4'd1, 0, 1'b0, 40'h0,          36'h0,         1'b1};
        vecs[10] = '{4'd3, 0, 1'b1, 40'h0,          36'h0,         1'b0};
        vecs[11] = '{4'd0, 5, 1'b1, 40'h8001FE7F3C, 36'h8001FE7FC, 1'b0};

        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            reset_dut();
            go(vecs[v].fmt, 1'b0);
            if (vecs[v].fmterr) begin
                chk("fmterr_flag", 64'({mtFMTERR, mtDONE, frmREADY}), 64'b110);
                @(negedge clk);
                chk("fmterr_after", 64'({mtFMTERR, mtDONE, frmREADY, wordVALID}), 64'b1000);
                continue;
            end
            chk("go_ready", 64'(frmREADY), 64'd1);
            fpw = (vecs[v].fmt == 4'd0) ? 5 : 4;
            for (int i = 0; i < vecs[v].n; i++) begin
                d = vecs[v].fr[39 - 8 * i -: 8];
                send_frame(d, good_par(d, 1'b0), 1'b0);
            end
            if (vecs[v].n == fpw) begin
                chk("word_latency", 64'(wordVALID), 64'd1);
                expect_word("vec_word", vecs[v].word);
                chk("resume_ready", 64'(frmREADY), 64'd1);
            end
            if (vecs[v].eor) begin
                send_frame(8'h00, 1'b0, 1'b1);
                if (vecs[v].n > 0 && vecs[v].n < fpw) begin
                    chk("flush_latency", 64'(wordVALID), 64'd1);
                    expect_word("vec_flush", vecs[v].word);
                end
                chk("eor_done", 64'({mtDONE, wordVALID}), 64'b10);
                @(negedge clk);
                chk("done_pulse", 64'(mtDONE), 64'd0);
            end
            chk("vec_fc", 64'(mtFC), 64'(vecs[v].n));
            chk("vec_fcs", 64'(mtFCS), 64'(vecs[v].n != 0));
        end

        // Counter load, wrap, load-vs-increment priority, GO ignored, backpressure.
        reset_dut();
        mtDATAI = 36'h0FFFE; mtFCLD = 1'b1;
        @(negedge clk);
        mtFCLD = 1'b0;
        chk("fcld_load", 64'({mtFCS, mtFC}), 64'h1FFFE);
        go(4'd3, 1'b0);
        mtTC = 16'h0050; mtGO = 1'b1;
        @(negedge clk);
        mtGO = 1'b0;
        chk("go_ignored", 64'({mtFMTERR, frmREADY, mtDONE}), 64'b010);
        send_frame(8'hA1, good_par(8'hA1, 1'b0), 1'b0);
        chk("fc_ffff", 64'({mtFCS, mtFC}), 64'h1FFFF);
        send_frame(8'hB2, good_par(8'hB2, 1'b0), 1'b0);
        chk("fc_wrap", 64'({mtFCS, mtFC}), 64'h00000);
        mtDATAI = 36'h00100; mtFCLD = 1'b1;
        send_frame(8'hC3, good_par(8'hC3, 1'b0), 1'b0);
        mtFCLD = 1'b0;
        chk("fcld_wins", 64'(mtFC), 64'h0100);
        send_frame(8'hD4, good_par(8'hD4, 1'b0), 1'b0);
        chk("fc_after4", 64'(mtFC), 64'h0101);
        chk("hold_latency", 64'(wordVALID), 64'd1);
        frmDATA = 8'h77; frmPAR = good_par(8'h77, 1'b0); frmEOR = 1'b0; frmVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(frmREADY), 64'd0);
            chk("stall_valid", 64'(wordVALID), 64'd1);
            chk("stall_data", 64'(wordDATA), 64'hA1B2C3D40);
        end
        chk("stall_fc", 64'(mtFC), 64'h0101);
        wordREADY = 1'b1;
        @(negedge clk);
        wordREADY = 1'b0;
        @(negedge clk);
        frmVALID = 1'b0;
        chk("post_stall_fc", 64'(mtFC), 64'h0102);
        send_frame(8'h00, 1'b0, 1'b1);
        chk("flush1_latency", 64'(wordVALID), 64'd1);
        expect_word("flush1_word", 36'h770000000);
        chk("flush1_done", 64'(mtDONE), 64'd1);
        @(negedge clk);

        // Parity sense.
        go(4'd3, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0);
`ifdef MT_PARCHK_EN
        perr_exp = 1'b1;
`else
        perr_exp = 1'b0;
`endif
        chk("perr_odd", 64'(mtPERR), 64'(perr_exp));
        send_frame(8'h00, 1'b0, 1'b1);
        expect_word("perr_word", 36'h010000000);
        chk("perr_done", 64'(mtDONE), 64'd1);
        @(negedge clk);
        chk("perr_sticky", 64'(mtPERR), 64'(perr_exp));
        go(4'd3, 1'b1);
        chk("perr_go_clear", 64'(mtPERR), 64'd0);
        send_frame(8'h01, 1'b1, 1'b0);
        chk("perr_even_ok", 64'(mtPERR), 64'd0);
        send_frame(8'h00, 1'b0, 1'b1);
        expect_word("perr_even_word", 36'h010000000);
        @(negedge clk);

        // Reset and INIT mid-word discard everything.
        go(4'd0, 1'b0);
        send_frame(8'h12, good_par(8'h12, 1'b0), 1'b0);
        send_frame(8'h34, good_par(8'h34, 1'b0), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midword", outs(), 64'd0);
        rst = 1'b0;
        go(4'd0, 1'b0);
        send_frame(8'h56, good_par(8'h56, 1'b0), 1'b0);
        mtINIT = 1'b1;
        @(negedge clk);
        chk("init_midword", outs(), 64'd0);
        mtINIT = 1'b0;
        go(4'd3, 1'b0);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), good_par(8'(i), 1'b0), 1'b0);
        expect_word("after_init_word", 36'h010203040);
        chk("after_init_fc", 64'(mtFC), 64'd4);
        send_frame(8'h00, 1'b0, 1'b1);
        chk("after_init_done", 64'(mtDONE), 64'd1);
        @(negedge clk);

        // Randomized operations against the word-level model.
        reset_dut();
        fc_m = 16'hFFF0 + 16'($urandom_range(0, 15));
        mtDATAI = {20'h0, fc_m}; mtFCLD = 1'b1;
        @(negedge clk);
        mtFCLD = 1'b0;
        chk("rnd_fcld", 64'(mtFC), 64'(fc_m));
        for (int op = 0; op < 25; op++) begin
            core = ($urandom_range(0, 1) == 1);
            ev   = 1'($urandom_range(0, 1));
            fpw  = core ? 5 : 4;
            go(core ? 4'd0 : 4'd3, ev);
            chk("rnd_go_ready", 64'(frmREADY), 64'd1);
            n = $urandom_range(0, 13);
            cur.delete();
            perr_m = 1'b0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                d = 8'($urandom);
                p = good_par(d, ev);
                if ($urandom_range(0, 7) == 0) begin
                    p = !p;
                    perr_m = 1'b1;
                end
                send_frame(d, p, 1'b0);
                cur.push_back(d);
                fc_m++;
                if (cur.size() == fpw) begin
                    chk("rnd_latency", 64'(wordVALID), 64'd1);
                    repeat ($urandom_range(0, 3)) begin
                        @(negedge clk);
                        chk("rnd_stall_ready", 64'(frmREADY), 64'd0);
                    end
                    expect_word("rnd_word", model_word(cur, core));
                    cur.delete();
                end
            end
            send_frame(8'h00, 1'b0, 1'b1);
            if (cur.size() > 0) begin
                chk("rnd_flush_latency", 64'(wordVALID), 64'd1);
                expect_word("rnd_flush", model_word(cur, core));
            end
            chk("rnd_done", 64'({mtDONE, wordVALID}), 64'b10);
            chk("rnd_fc", 64'(mtFC), 64'(fc_m));
            chk("rnd_fcs", 64'(mtFCS), 64'(fc_m != 16'd0));
`ifdef MT_PARCHK_EN
            perr_exp = perr_m;
`else
            perr_exp = 1'b0;
`endif
            chk("rnd_perr", 64'(mtPERR), 64'(perr_exp));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
